// File: rtl/matrix_buffer_nb_if.sv
// matrix_buffer_nb_if: row-stream bus for the matrix buffer.
// Carries the upstream row handshake, the downstream row handshake
// and the sticky protocol error flag. Rows are packed with sample j at [j].
interface matrix_buffer_nb_if #(
    parameter int W_IO = 16,
    parameter int N    = 8
);
    // upstream side
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0][W_IO-1:0]   in_data;
    logic                     in_sob;
    logic                     in_eob;
    logic                     in_sof;
    logic                     in_trps;
    // downstream side
    logic                     out_valid;
    logic                     out_ready;
    logic [N-1:0][W_IO-1:0]   out_data;
    logic                     out_sob;
    logic                     out_eob;
    logic                     out_sof;
    // status
    logic                     err;

    modport master (
        output in_valid, in_data, in_sob, in_eob, in_sof, in_trps, out_ready,
        input  in_ready, out_valid, out_data, out_sob, out_eob, out_sof, err
    );

    modport slave (
        input  in_valid, in_data, in_sob, in_eob, in_sof, in_trps, out_ready,
        output in_ready, out_valid, out_data, out_sob, out_eob, out_sof, err
    );
endinterface

// File: rtl/matrix_buffer_nb.sv
// matrix_buffer_nb: NBUF-bank block buffer between row stages.
// Collects N rows of N samples per block into a bank, then replays the
// block row by row (or column by column when the bank's trps flag is set)
// with valid/ready on both sides. Framing is purely by row count.
// Optional protocol checker: define MATRIX_BUFFER_NB_CHECK_EN to make err
// flag any accepted row whose in_sob/in_eob disagree with the row count.
module matrix_buffer_nb #(
    parameter int W_IO      = 16,
    parameter int N         = 8,
    parameter int NBUF      = 2,
    parameter int TRPS_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    matrix_buffer_nb_if.slave   bus
);
    localparam int RW = $clog2(N);
    localparam int PW = $clog2(NBUF);
    localparam int CW = $clog2(NBUF + 1);

    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [PW-1:0] LAST_BUF = PW'(NBUF - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NBUF);
    localparam logic          TRPS_FIX = (TRPS_MODE == 1);

    typedef logic [N-1:0][W_IO-1:0] row_t;

    // bank storage and per-bank attributes captured on row 0
    logic [NBUF-1:0][N-1:0][N-1:0][W_IO-1:0] mem_q;
    logic [NBUF-1:0]                         sof_q;
    logic [NBUF-1:0]                         trps_q;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [RW-1:0] wrow_q, wrow_d;
    logic [RW-1:0] rrow_q, rrow_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          out_valid_q;

    logic in_ready;
    logic in_acc, out_acc;
    logic in_last, out_last;
    logic blk_close, blk_drain;
    logic wtrps;

    assign in_ready  = en & (cnt_q < FULL_CNT);
    assign in_acc    = bus.in_valid & in_ready;
    assign out_acc   = out_valid_q & bus.out_ready & en;
    assign in_last   = (wrow_q == LAST_ROW);
    assign out_last  = (rrow_q == LAST_ROW);
    assign blk_close = in_acc & in_last;
    assign blk_drain = out_acc & out_last;
    // TRPS_MODE 2 takes the per-block pin, otherwise the fixed mode bit
    assign wtrps     = (TRPS_MODE == 2) ? bus.in_trps : TRPS_FIX;

    // next-state for pointers, row counters and occupancy
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        wrow_d = wrow_q;
        rrow_d = rrow_q;
        cnt_d  = cnt_q;
        if (in_acc) begin
            wrow_d = in_last ? '0 : wrow_q + 1'b1;
            if (in_last)
                wptr_d = (wptr_q == LAST_BUF) ? '0 : wptr_q + 1'b1;
        end
        if (out_acc) begin
            rrow_d = out_last ? '0 : rrow_q + 1'b1;
            if (out_last)
                rptr_d = (rptr_q == LAST_BUF) ? '0 : rptr_q + 1'b1;
        end
        // a close and a drain in the same cycle cancel out
        case ({blk_close, blk_drain})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // control registers; en=0 leaves every _d equal to its _q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wrow_q      <= '0;
            rrow_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wrow_q      <= wrow_d;
            rrow_q      <= rrow_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (cnt_d != '0);
        end
    end

    // bank write path: row data every accept, block attributes on row 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            sof_q  <= '0;
            trps_q <= '0;
        end else if (in_acc) begin
            mem_q[wptr_q][wrow_q] <= bus.in_data;
            if (wrow_q == '0) begin
                sof_q[wptr_q]  <= bus.in_sof;
                trps_q[wptr_q] <= wtrps;
            end
        end
    end

    // read path: pick row rrow, or gather column rrow across all rows
    row_t rd_row, rd_col;
    assign rd_row = mem_q[rptr_q][rrow_q];
    for (genvar j = 0; j < N; j++) begin : g_col
        assign rd_col[j] = mem_q[rptr_q][j][rrow_q];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = trps_q[rptr_q] ? rd_col : rd_row;
    assign bus.out_sob   = out_valid_q & (rrow_q == '0);
    assign bus.out_eob   = out_valid_q & out_last;
    assign bus.out_sof   = out_valid_q & (rrow_q == '0) & sof_q[rptr_q];

`ifdef MATRIX_BUFFER_NB_CHECK_EN
    logic err_q, err_d;

    // flag framing markers that disagree with the row count
    always_comb begin
        err_d = err_q;
        if (in_acc && ((bus.in_sob != (wrow_q == '0)) || (bus.in_eob != in_last)))
            err_d = 1'b1;
    end

    // sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    // framing markers are not observed when the checker is left out
    logic unused_chk;
    assign unused_chk = ^{bus.in_sob, bus.in_eob};
    assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_buffer_nb.sv
// tb_matrix_buffer_nb: scoreboard bench for matrix_buffer_nb (N=8, NBUF=3,
// per-block transpose). The driver records each accepted block and, on the
// closing row, queues the N rows the block must come out as; a monitor on
// the falling edge compares the DUT against that queue and block counts.
module tb_matrix_buffer_nb;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int NB = 3;

    typedef logic [N-1:0][W-1:0] row_t;
    typedef struct {
        row_t d;
        bit   sob;
        bit   eob;
        bit   sof;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;

    matrix_buffer_nb_if #(.W_IO(W), .N(N)) bus ();

    matrix_buffer_nb #(.W_IO(W), .N(N), .NBUF(NB), .TRPS_MODE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nmis = 0;
    exp_t exp_q[$];
    int   blocks_in  = 0;
    int   blocks_out = 0;
    bit   err_exp    = 1'b0;
    int   en_mode    = 0;   // 0: en held 1, 1: random
    int   rdy_mode   = 1;   // 0: out_ready 0, 1: 1, 2: random

    // reference block being assembled
    row_t blk [N];
    bit   blk_sof, blk_trps;
    int   wrow_m = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // en / out_ready pattern generator
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            en            = (en_mode == 0) ? 1'b1 : ($urandom_range(7) != 0);
            bus.out_ready = (rdy_mode == 0) ? 1'b0 :
                            (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(1));
        end
    end

    // monitor: compare flags every cycle, rows whenever out_valid
    initial begin
        forever begin
            bit   drain;
            int   cnt;
            exp_t e;
            @(negedge clk);
            drain = 1'b0;
            cnt   = blocks_in - blocks_out;
            chk("in_ready",  bus.in_ready,  en && (cnt < NB));
            chk("out_valid", bus.out_valid, cnt > 0);
`ifdef MATRIX_BUFFER_NB_CHECK_EN
            chk("err", bus.err, err_exp);
`else
            chk("err", bus.err, 1'b0);
`endif
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL out_unexpected: got row %0h want none at %0t", bus.out_data, $time);
                end else begin
                    e = exp_q[0];
                    chk("out_data", bus.out_data, e.d);
                    chk("out_sob",  bus.out_sob,  e.sob);
                    chk("out_eob",  bus.out_eob,  e.eob);
                    chk("out_sof",  bus.out_sof,  e.sof);
                    if (bus.out_ready && en) begin
                        void'(exp_q.pop_front());
                        if (e.eob) drain = 1'b1;
                    end
                end
            end else begin
                chk("idle_sob", bus.out_sob, 1'b0);
                chk("idle_eob", bus.out_eob, 1'b0);
                chk("idle_sof", bus.out_sof, 1'b0);
            end
            if (drain) begin
                @(posedge clk); #1;
                blocks_out++;
            end
        end
    end

    task automatic finish_tb();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    endtask

    // offer one row until accepted, then update the reference block
    task automatic send_row(input row_t d, input bit sob, input bit eob,
                            input bit sof, input bit trps);
        int t = 0;
        bit acc = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sob   = sob;
        bus.in_eob   = eob;
        bus.in_sof   = sof;
        bus.in_trps  = trps;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready && en;
            @(posedge clk); #1;
            if (!acc) begin
                t++;
                if (t > 2000) begin
                    nvec++; nmis++;
                    $display("FAIL in_accept_timeout: row %0d never accepted at %0t", wrow_m, $time);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        if (sob != (wrow_m == 0) || eob != (wrow_m == N - 1)) err_exp = 1'b1;
        blk[wrow_m] = d;
        if (wrow_m == 0) begin
            blk_sof  = sof;
            blk_trps = trps;
        end
        if (wrow_m == N - 1) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++)
                    e.d[j] = blk_trps ? blk[j][k] : blk[k][j];
                e.sob = (k == 0);
                e.eob = (k == N - 1);
                e.sof = (k == 0) && blk_sof;
                exp_q.push_back(e);
            end
            blocks_in++;
            wrow_m = 0;
        end else begin
            wrow_m++;
        end
    endtask

    // pat 0: sample = 8r+j (+base); pat 1: random samples
    task automatic send_block(input int pat, input int base, input bit trps,
                              input bit sof, input int eob_row, input int rows);
        row_t d;
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < N; j++)
                d[j] = (pat == 0) ? W'(base + 8 * r + j) : W'($urandom);
            send_row(d, r == 0, r == eob_row, sof, trps);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || blocks_in != blocks_out) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        nvec++;
        if (exp_q.size() != 0) begin
            nmis++;
            $display("FAIL drain_timeout: %0d rows left want 0 at %0t", exp_q.size(), $time);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sob   = 1'b0;
        bus.in_eob   = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_trps  = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // plain block with sof, then one without
        send_block(0, 0, 1'b0, 1'b1, N - 1, N);
        send_block(0, 100, 1'b0, 1'b0, N - 1, N);
        wait_drain();

        // transposed block then plain block, back to back
        send_block(0, 0, 1'b1, 1'b0, N - 1, N);
        send_block(0, 200, 1'b0, 1'b0, N - 1, N);
        wait_drain();

        // fill all banks with the output stalled, then release
        rdy_mode = 0;
        fork
            begin
                for (int b = 0; b < 4; b++)
                    send_block(0, 64 * b, (b % 2) == 1, b == 0, N - 1, N);
            end
            begin
                int t = 0;
                while (blocks_in < NB && t < 1000) begin
                    @(posedge clk);
                    t++;
                end
                repeat (6) @(posedge clk);
                #1 rdy_mode = 1;
            end
        join
        wait_drain();

        // early eob on row 5; block still closes on row count
        send_block(0, 300, 1'b0, 1'b0, 5, N);
        wait_drain();

        // randomized traffic with stalls on both sides
        en_mode  = 1;
        rdy_mode = 2;
        for (int b = 0; b < 20; b++)
            send_block(1, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), N - 1, N);
        wait_drain();
        en_mode  = 0;
        rdy_mode = 1;
        @(posedge clk); #1;

        // reset after four rows of a block, then a complete block
        send_block(0, 500, 1'b0, 1'b1, N - 1, 4);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        blocks_in  = 0;
        blocks_out = 0;
        wrow_m     = 0;
        err_exp    = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(0, 700, 1'b1, 1'b1, N - 1, N);
        wait_drain();

        repeat (4) @(posedge clk);
        finish_tb();
    end

    // global watchdog
    initial begin
        #2000000;
        nvec++; nmis++;
        $display("FAIL watchdog: run still active at %0t want finished", $time);
        finish_tb();
    end
endmodule

// File: doc/matrix_buffer_nb.md
Name: matrix_buffer_nb

Overview:
- Parametrised successor of the 8x8 ping-pong row buffer.
- Accepts N rows of N samples per block into one of NBUF banks. Emits each completed block row by row, optionally transposed, with a per-block transpose choice.
- Adds valid/ready backpressure on both sides, configurable bank depth and protocol error detection.
- Sits between row-DCT/quantiser stages of the JPEG pipeline.

Parameters:
- W_IO, 16: sample width in bits.
- N, 8: block dimension; rows per block and samples per row; power of two, 2..16.
- NBUF, 2: number of block banks; 2..8.
- TRPS_MODE, 0: 0 = never transpose, 1 = always transpose, 2 = per-block select via in_trps.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global stall; when 0 no state changes.
- in_valid  in  1  input row valid.
- in_ready  out  1  buffer can accept a row.
- in_data  in  N*W_IO  packed row, sample j at [j].
- in_sob  in  1  first row of block.
- in_eob  in  1  last row of block.
- in_sof  in  1  first block of frame; meaningful with in_sob.
- in_trps  in  1  transpose this block; sampled on the row-0 accept; used only when TRPS_MODE=2.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accepts row.
- out_data  out  N*W_IO  output row.
- out_sob  out  1  first output row of block.
- out_eob  out  1  last output row of block.
- out_sof  out  1  first output row of a block captured with in_sof.
- err  out  1  sticky protocol error.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_sob/out_eob/out_sof=0, err=0. Write/read bank pointers, row counters and occupancy count are 0. Bank contents are 0.
- Input accept = in_valid & in_ready & en.
- in_ready = en & (count < NBUF).
- Each accept writes in_data to bank[wptr] row[wrow], then wrow increments.
- Row 0 accept also latches the bank's sof flag (in_sof) and trps flag. The trps flag is in_trps if TRPS_MODE=2, else TRPS_MODE[0].
- Block closes on the accept with wrow=N-1: wrow←0, wptr←(wptr+1) mod NBUF, count increments.
- Output: out_valid is registered and =1 whenever count>0. First row is visible the cycle after the closing accept, giving 1-cycle latency.
- Output accept = out_valid & out_ready & en. It advances rrow. On rrow=N-1: rrow←0, rptr←(rptr+1) mod NBUF, count decrements.
- out_data is combinational from bank[rptr]:
  - trps=0: row rrow.
  - trps=1: column rrow, i.e. sample j = row j, sample rrow.
- out_sob = out_valid & (rrow==0). out_eob = out_valid & (rrow==N-1). out_sof = out_valid & (rrow==0) & sof flag of bank[rptr].
- Output holds stable while out_valid & !out_ready. Data may not change until accepted.
- Simultaneous block close on input and block drain on output: count unchanged. This permits full-rate streaming when NBUF≥2.
- Full (count=NBUF): in_ready=0. An in_valid held high is not lost. A drain completion raises in_ready the next cycle.
- Empty: out_valid=0; out_ready ignored.
- Pointer wrap: mod NBUF, correct for non-power-of-two NBUF.
- Block framing is by row count only. in_sob/in_eob are checked, not obeyed.
- en=0 freezes all registers; in_ready=0; out_valid is held but no output accept occurs.
- Reset mid-block: partial block discarded, all state returns to reset values.

Optional Feature:
- Macro MATRIX_BUFFER_NB_CHECK_EN.
- Defined: err is set and held until reset on any input accept where in_sob ≠ (wrow==0) or in_eob ≠ (wrow==N-1).
- Not defined: no checking logic; err is tied to 0. Datapath behaviour is identical in both cases.

Test Plan:
- N=8, NBUF=2, TRPS_MODE=0. Send block rows r with data[j]=8r+j, out_ready=1.
  → out_valid rises 1 cycle after row 7. Rows out in order, out_sob on row 0, out_eob on row 7.
- TRPS_MODE=2. Block A with in_trps=1, block B with in_trps=0, back-to-back.
  → A row k sample j = 8j+k. B untransposed. No gaps, in_ready stays 1.
- NBUF=3, out_ready=0. Send 4 blocks.
  → in_ready falls after 24th row. Raise out_ready: 4th block accepted after first drain completes; all 32 rows correct in order.
- in_sof=1 on block 0 only.
  → out_sof=1 only on block 0 row 0.
- Check macro defined. Assert in_eob on row 5.
  → err=1 the next cycle and sticky. Block still closes after row 7.
- Assert rst_n low after row 3, then resend a full block.
  → All outputs reset. Only the new block is emitted, with correct data.
